// File: rtl/kernel_flush_seq_if.sv
// kernel_flush_seq_if: dtype-tagged pixel stream into and out of kernel_flush_seq, plus busy.
// Defines fallback dtype codes when the shared dtype header has not been included.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 8
`endif
`ifndef FRAME_START
`define FRAME_START 8'h01
`endif
`ifndef FRAME_END
`define FRAME_END 8'h02
`endif
`ifndef ROW_START
`define ROW_START 8'h04
`endif
`ifndef ROW_END
`define ROW_END 8'h08
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 8'hF0
`endif

interface kernel_flush_seq_if #(
   parameter int unsigned DATA_WIDTH = 8
) ();
   logic                    dvi;
   logic [`DTYPE_WIDTH-1:0] dtypei;
   logic [DATA_WIDTH-1:0]   datai;
   logic                    dvo;
   logic [`DTYPE_WIDTH-1:0] dtypeo;
   logic [DATA_WIDTH-1:0]   datao;
   logic                    busy;

   modport slave (input dvi, dtypei, datai, output dvo, dtypeo, datao, busy);
   modport master (output dvi, dtypei, datai, input dvo, dtypeo, datao, busy);
endinterface

// File: rtl/kernel_flush_seq.sv
// kernel_flush_seq: 1-cycle registered pass-through that injects PAD_ROWS constant rows per frame.
// Define KERNEL_FLUSH_SEQ_STATS_EN to add the num_rows and frame_cnt outputs.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 8
`endif
`ifndef FRAME_START
`define FRAME_START 8'h01
`endif
`ifndef FRAME_END
`define FRAME_END 8'h02
`endif
`ifndef ROW_START
`define ROW_START 8'h04
`endif
`ifndef ROW_END
`define ROW_END 8'h08
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 8'hF0
`endif

module kernel_flush_seq #(
   parameter int unsigned           DATA_WIDTH     = 8,
   parameter int unsigned           NUM_COLS_WIDTH = 11,
   parameter int unsigned           PAD_ROWS       = 1,
   parameter logic [DATA_WIDTH-1:0] PAD_VALUE      = '0
) (
   input  logic                      clk,
   input  logic                      resetb,
   input  logic                      enable,
   kernel_flush_seq_if.slave         bus,
   output logic                      overrun,
   output logic [NUM_COLS_WIDTH-1:0] num_cols
`ifdef KERNEL_FLUSH_SEQ_STATS_EN
   ,
   output logic [9:0]                num_rows,
   output logic [15:0]               frame_cnt
`endif
);

   typedef enum logic [2:0] {StIdle, StFrame, StPadRs, StPadPix, StPadRe, StPadFe} state_e;

   localparam logic [3:0] PadRows = 4'(PAD_ROWS);

   state_e                    state_q, state_d;
   logic                      en_q, en_d;
   logic [NUM_COLS_WIDTH-1:0] col_cnt_q, col_cnt_d;
   logic [9:0]                row_cnt_q, row_cnt_d;
   logic [NUM_COLS_WIDTH-1:0] pad_col_q, pad_col_d;
   logic [2:0]                pad_row_q, pad_row_d;
   logic [`DTYPE_WIDTH-1:0]   pix_dtype_q, pix_dtype_d;
   logic                      dvo_q, dvo_d;
   logic [`DTYPE_WIDTH-1:0]   dtypeo_q, dtypeo_d;
   logic [DATA_WIDTH-1:0]     datao_q, datao_d;
   logic                      busy_q, busy_d;
   logic                      overrun_q, overrun_d;
   logic [NUM_COLS_WIDTH-1:0] num_cols_q, num_cols_d;

   logic                      is_pixel, start_pad, last_pad_row;
   logic [NUM_COLS_WIDTH-1:0] pad_col_inc;

   assign is_pixel     = (bus.dtypei & `DTYPE_PIXEL_MASK) != '0;
   assign start_pad    = en_q && (PadRows != 4'd0) && (row_cnt_q != '0);
   assign pad_col_inc  = pad_col_q + NUM_COLS_WIDTH'(1);
   assign last_pad_row = ({1'b0, pad_row_q} + 4'd1) == PadRows;

   always_ff @(posedge clk) begin
      if (!resetb) state_q <= StIdle;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (bus.dvi && bus.dtypei == `FRAME_START) state_d = StFrame;
         StFrame:  if (bus.dvi && bus.dtypei == `FRAME_END) state_d = start_pad ? StPadRs : StIdle;
         StPadRs:  state_d = (num_cols_q == '0) ? StPadRe : StPadPix;
         StPadPix: if (pad_col_inc == num_cols_q) state_d = StPadRe;
         StPadRe:  state_d = last_pad_row ? StPadFe : StPadRs;
         StPadFe:  state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      en_d        = en_q;
      col_cnt_d   = col_cnt_q;
      row_cnt_d   = row_cnt_q;
      pad_col_d   = pad_col_q;
      pad_row_d   = pad_row_q;
      pix_dtype_d = pix_dtype_q;
      dvo_d       = 1'b0;
      dtypeo_d    = dtypeo_q;
      datao_d     = datao_q;
      busy_d      = busy_q;
      overrun_d   = overrun_q;
      num_cols_d  = num_cols_q;
      unique case (state_q)
         StIdle, StFrame: begin
            if (bus.dvi) begin
               dvo_d    = 1'b1;
               dtypeo_d = bus.dtypei;
               datao_d  = bus.datai;
               if (bus.dtypei == `FRAME_START) begin
                  en_d      = enable;
                  col_cnt_d = '0;
                  row_cnt_d = '0;
                  if (state_q == StIdle) overrun_d = 1'b0;
               end else if (state_q == StFrame) begin
                  if (bus.dtypei == `ROW_START) begin
                     col_cnt_d = '0;
                  end else if (is_pixel) begin
                     if (~&col_cnt_q) col_cnt_d = col_cnt_q + NUM_COLS_WIDTH'(1);
                     pix_dtype_d = bus.dtypei;
                  end else if (bus.dtypei == `ROW_END) begin
                     if (row_cnt_q == '0) num_cols_d = col_cnt_q;
                     if (~&row_cnt_q) row_cnt_d = row_cnt_q + 10'd1;
                  end else if (bus.dtypei == `FRAME_END && start_pad) begin
                     // Frame end is held back and re-emitted after the synthetic rows.
                     dvo_d     = 1'b0;
                     dtypeo_d  = dtypeo_q;
                     datao_d   = datao_q;
                     busy_d    = 1'b1;
                     pad_row_d = '0;
                  end
               end
            end
         end
         StPadRs: begin
            dvo_d     = 1'b1;
            dtypeo_d  = `ROW_START;
            datao_d   = '0;
            pad_col_d = '0;
         end
         StPadPix: begin
            dvo_d     = 1'b1;
            dtypeo_d  = pix_dtype_q;
            datao_d   = PAD_VALUE;
            pad_col_d = pad_col_inc;
         end
         StPadRe: begin
            dvo_d     = 1'b1;
            dtypeo_d  = `ROW_END;
            datao_d   = '0;
            pad_row_d = pad_row_q + 3'd1;
         end
         StPadFe: begin
            dvo_d    = 1'b1;
            dtypeo_d = `FRAME_END;
            datao_d  = '0;
            busy_d   = 1'b0;
         end
         default: ;
      endcase
      // Upstream words arriving during injection are dropped.
      if (busy_q && bus.dvi) overrun_d = 1'b1;
   end

`ifdef KERNEL_FLUSH_SEQ_STATS_EN
   logic [9:0]  num_rows_q, num_rows_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic        fe_emit;

   always_comb begin
      fe_emit     = dvo_d && (dtypeo_d == `FRAME_END);
      num_rows_d  = fe_emit ? row_cnt_q : num_rows_q;
      frame_cnt_d = fe_emit ? frame_cnt_q + 16'd1 : frame_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (!resetb) begin
         num_rows_q  <= '0;
         frame_cnt_q <= '0;
      end else begin
         num_rows_q  <= num_rows_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign num_rows  = num_rows_q;
   assign frame_cnt = frame_cnt_q;
`endif

   always_ff @(posedge clk) begin
      if (!resetb) begin
         en_q        <= 1'b0;
         col_cnt_q   <= '0;
         row_cnt_q   <= '0;
         pad_col_q   <= '0;
         pad_row_q   <= '0;
         pix_dtype_q <= '0;
         dvo_q       <= 1'b0;
         dtypeo_q    <= '0;
         datao_q     <= '0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
         num_cols_q  <= '0;
      end else begin
         en_q        <= en_d;
         col_cnt_q   <= col_cnt_d;
         row_cnt_q   <= row_cnt_d;
         pad_col_q   <= pad_col_d;
         pad_row_q   <= pad_row_d;
         pix_dtype_q <= pix_dtype_d;
         dvo_q       <= dvo_d;
         dtypeo_q    <= dtypeo_d;
         datao_q     <= datao_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
         num_cols_q  <= num_cols_d;
      end
   end

   assign bus.dvo    = dvo_q;
   assign bus.dtypeo = dtypeo_q;
   assign bus.datao  = datao_q;
   assign bus.busy   = busy_q;
   assign overrun    = overrun_q;
   assign num_cols   = num_cols_q;

endmodule

// File: doc/kernel_flush_seq.md
Name: kernel_flush_seq

Overview:
- Sequencer placed directly upstream of the 2-D image kernel in the pixel pipeline.
- Passes the dtype-tagged pixel stream through with one cycle of registered latency.
- At each frame end it injects PAD_ROWS synthetic rows of constant pixels before forwarding the frame-end word. This flushes the kernel row buffers so the last image rows reach the kernel output.
- Measures row width, and flags upstream words that arrive while injection is in progress.

Parameters:
- DATA_WIDTH, 8, pixel width.
- NUM_COLS_WIDTH, 11, width of the column counter and of num_cols.
- PAD_ROWS, 1, synthetic rows injected per frame; legal range 0..7. Set to KERNEL_SIZE/2 of the downstream kernel.
- PAD_VALUE, 0, pixel value used for injected pixels.

Ports:
- clk  in  1  clock.
- resetb  in  1  reset; synchronous, active-low.
- enable  in  1  padding enable; sampled only on FRAME_START.
- dvi  in  1  input word valid.
- dtypei  in  `DTYPE_WIDTH  input word type.
- datai  in  DATA_WIDTH  input pixel.
- dvo  out  1  output word valid.
- dtypeo  out  `DTYPE_WIDTH  output word type.
- datao  out  DATA_WIDTH  output pixel.
- busy  out  1  high while injecting; upstream must hold dvi low.
- overrun  out  1  sticky; set when dvi=1 while busy=1.
- num_cols  out  NUM_COLS_WIDTH  pixel count of the first row of the current or last frame.

Behaviour:
- Reset (resetb=0 at a clk edge): dvo=0, dtypeo=0, datao=0, busy=0, overrun=0, num_cols=0, state=IDLE, internal counters=0.
- All outputs are registered.
- Pass-through latency: 1 cycle. When dvi=1 and not injecting, on the next edge dvo=1, dtypeo=dtypei, datao=datai.
- When dvi=0 and not injecting, dvo=0 on the next edge; dtypeo/datao hold.
- States:
  - IDLE: pass-through. FRAME_START latches en_q=enable, clears col_cnt and row_cnt, then goes to FRAME.
  - FRAME: pass-through.
    - ROW_START clears col_cnt.
    - Each pixel word (dtypei & `DTYPE_PIXEL_MASK nonzero) increments col_cnt, saturating at all-ones, and latches pix_dtype=dtypei.
    - ROW_END: if row_cnt==0, num_cols<=col_cnt; row_cnt increments, saturating.
    - FRAME_END: if en_q=1, PAD_ROWS>0 and row_cnt>0, the FRAME_END is swallowed (dvo=0 that cycle), busy<=1, state becomes PAD_RS. Otherwise FRAME_END passes through and state becomes IDLE.
  - PAD_RS: emit ROW_START (datao=0), clear pad_col, go to PAD_PIX. If num_cols==0, go straight to PAD_RE.
  - PAD_PIX: emit dtypeo=pix_dtype, datao=PAD_VALUE, one per cycle; pad_col++. After num_cols pixels, go to PAD_RE.
  - PAD_RE: emit ROW_END; pad_row++. If pad_row==PAD_ROWS go to PAD_FE, else go to PAD_RS.
  - PAD_FE: emit FRAME_END, busy<=0, state becomes IDLE.
- Injected words carry dvo=1 every cycle (no gaps).
- Injected row/column counts do not update num_cols or row_cnt.
- Injection length is exactly PAD_ROWS*(num_cols+2)+1 output words. busy is high from the cycle after FRAME_END is accepted through the cycle PAD_FE is emitted.
- Overrun:
  - Any dvi=1 while busy=1 sets overrun; the word is dropped.
  - overrun clears only on reset or on a FRAME_START accepted in IDLE.
- Other cases:
  - FRAME_START received in FRAME restarts the frame with no injection.
  - Unknown dtypes pass through unchanged.
- Reset asserted mid-injection returns everything to reset values on that edge; no further injected words are emitted.

Optional Feature:
- Macro: KERNEL_FLUSH_SEQ_STATS_EN.
- With it defined:
  - Adds output num_rows [9:0]. It is loaded with row_cnt (excluding injected rows) on the cycle the frame-end word is emitted, and reset to 0.
  - Adds output frame_cnt [15:0], which increments, wrapping, on every emitted FRAME_END.
- Without it: neither port exists; behaviour is otherwise identical.

Test Plan:
- Frame of 3 rows x 4 cols, enable=1, PAD_ROWS=1, PAD_VALUE=0 -> after the input FRAME_END, exactly 7 words: ROW_START, 4 pixels of 0, ROW_END, FRAME_END. busy is high for those 7 cycles; num_cols=4.
- Same frame, enable=0 -> output identical to input delayed 1 cycle, no injected words, busy never high.
- PAD_ROWS=2, 2x5 frame, PAD_VALUE=8'hAA -> 15 injected words; pixel words datao=8'hAA with dtypeo equal to the last input pixel dtype.
- dvi=1 pixel applied while busy=1 -> overrun=1, word absent from output. The next FRAME_START in IDLE clears overrun.
- resetb=0 on the 3rd injected cycle -> next cycle dvo=0, busy=0, num_cols=0, state IDLE. A following 1x2 frame passes with a correct 5-word flush.
- First row of 6 pixels, second row of 3 -> num_cols=6 and injected rows contain 6 pixels. With STATS_EN: num_rows=2 and frame_cnt increments by 1.
